// File: rtl/alu_pkg.sv
// Shared definitions for the shift sequencer.
//   - ALUFun shift encodings (bit 0 = right, bit 1 = arithmetic fill)
//   - sequencer state enum
//   - barrel stage amounts, largest first; each is one-hot, so it also
//     serves as the mask of the shift-amount bit it consumes
//   - shift helper used by the barrel stage
package alu_pkg;

  localparam logic [1:0] FUN_SLL = 2'b00;
  localparam logic [1:0] FUN_SRL = 2'b01;
  localparam logic [1:0] FUN_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } shseq_state_t;

  localparam int unsigned NUM_STAGES = 5;
  localparam logic [4:0] STAGE_AMT [NUM_STAGES] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

  // Shift v by k; on right shifts the vacated upper bits take 'fill'.
  function automatic logic [31:0] shift_k(
    input logic [31:0] v,
    input logic [4:0]  k,
    input logic        right,
    input logic        fill
  );
    logic [31:0] fill_mask;
    fill_mask = fill ? ~(32'hFFFF_FFFF >> k) : '0;
    return right ? ((v >> k) | fill_mask) : (v << k);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel stage of the shift sequencer (combinational).
// Applies the largest power-of-two amount whose bit is set in rem and
// clears that bit. With rem == 0 both values pass through unchanged.
//   acc      : current partial result
//   rem      : shift amount still to apply
//   fun      : ALUFun ([0]=right, [1]=arithmetic fill)
//   sign     : latched sign of the original operand
//   acc_next : partial result after this stage
//   rem_next : remaining amount after this stage
module shift_stage
  import alu_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [4:0]  rem,
  input  logic [1:0]  fun,
  input  logic        sign,
  output logic [31:0] acc_next,
  output logic [4:0]  rem_next
);

  logic right;
  logic fill;
  logic found;

  assign right = fun[0];
  // Fill uses the original operand sign, not the intermediate acc[31].
  assign fill  = fun[1] & sign;

  always_comb begin
    acc_next = acc;
    rem_next = rem;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!found && ((rem & STAGE_AMT[i]) != '0)) begin
        found    = 1'b1;
        acc_next = shift_k(acc, STAGE_AMT[i], right, fill);
        rem_next = rem & ~STAGE_AMT[i];
      end
    end
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift sequencer for the execute stage.
// Accepts one SLL/SRL/SRA request at a time, applies one barrel stage per
// set bit of the shift amount, then holds the result with its tag until
// the writeback side accepts it. flush drops any in-flight or held work.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous abort (beats req_valid)
//   req_valid/req_ready : request handshake
//   req_a/req_shamt     : operand and shift amount
//   req_fun/req_tag     : ALUFun and destination tag
//   rsp_valid/rsp_ready : response handshake
//   rsp_s/rsp_tag       : result and its tag
//   busy                : sequencer not idle
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [W-1:0]    req_a,
  input  logic [4:0]      req_shamt,
  input  logic [1:0]      req_fun,
  input  logic [TAGW-1:0] req_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_s,
  output logic [TAGW-1:0] rsp_tag,
  output logic            busy
);

  shseq_state_t state, state_next;

  logic [W-1:0]    acc, acc_d;
  logic [4:0]      rem, rem_d;
  logic [1:0]      fun, fun_d;
  logic [TAGW-1:0] tag, tag_d;
  logic            sign, sign_d;

  logic [W-1:0]    stage_acc;
  logic [4:0]      stage_rem;

  shift_stage u_stage (
    .acc      (acc),
    .rem      (rem),
    .fun      (fun),
    .sign     (sign),
    .acc_next (stage_acc),
    .rem_next (stage_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      rem   <= '0;
      fun   <= '0;
      tag   <= '0;
      sign  <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_d;
      rem   <= rem_d;
      fun   <= fun_d;
      tag   <= tag_d;
      sign  <= sign_d;
    end
  end

  always_comb begin
    state_next = state;
    acc_d      = acc;
    rem_d      = rem;
    fun_d      = fun;
    tag_d      = tag;
    sign_d     = sign;

    unique case (state)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          acc_d      = req_a;
          rem_d      = req_shamt;
          fun_d      = req_fun;
          tag_d      = req_tag;
          sign_d     = req_a[W-1];
          state_next = (req_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = stage_acc;
        rem_d = stage_rem;
        if (stage_rem == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (flush) begin
      state_next = ST_IDLE;
    end
  end

  // All handshake outputs decode from registered state only.
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign rsp_s     = acc;
  assign rsp_tag   = tag;

endmodule

// File: tb/tb_alu_shift_seq.sv
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [4:0]  req_shamt;
  logic [1:0]  req_fun;
  logic [4:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_s;
  logic [4:0]  rsp_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_shift_seq #(.W(32), .TAGW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_shamt (req_shamt),
    .req_fun   (req_fun),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Offer a request, measure edges from accept (inclusive) to rsp_valid,
  // check result/tag, then complete the response handshake.
  task automatic do_req(input string name, input logic [31:0] a, input logic [4:0] sh,
                        input logic [1:0] fn, input logic [4:0] tg,
                        input logic [31:0] exp_s, input int exp_lat);
    int lat;
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_shamt = sh;
    req_fun   = fn;
    req_tag   = tg;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      check({name, "_wait_ready"}, 32'(req_ready), 32'd0);
      tick();
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_s"}, rsp_s, exp_s);
    check({name, "_tag"}, 32'(rsp_tag), 32'(tg));
    check({name, "_busy"}, 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({name, "_drop"}, 32'(rsp_valid), 32'd0);
    check({name, "_rdy_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_shamt = '0;
    req_fun   = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_s", rsp_s, 32'h0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    do_req("sll31", 32'h0000_0001, 5'd31, 2'b00, 5'd3, 32'h8000_0000, 6);
    do_req("sra20", 32'h8000_00F0, 5'd20, 2'b11, 5'd4, 32'hFFFF_F800, 3);
    do_req("srl20", 32'h8000_00F0, 5'd20, 2'b01, 5'd5, 32'h0000_0800, 3);
    do_req("sh0",   32'hDEAD_BEEF, 5'd0,  2'b01, 5'd6, 32'hDEAD_BEEF, 1);
    do_req("fun10", 32'h0000_000F, 5'd3,  2'b10, 5'd8, 32'h0000_0078, 3);
    do_req("srl8",  32'hFF00_FF00, 5'd8,  2'b01, 5'd31, 32'h00FF_00FF, 2);

    // Backpressure with a competing request offered while DONE is held.
    req_valid = 1'b1;
    req_a = 32'h1234_5678; req_shamt = 5'd4; req_fun = 2'b00; req_tag = 5'd7;
    tick();
    req_a = 32'hF000_0000; req_shamt = 5'd1; req_fun = 2'b11; req_tag = 5'd9;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_s", rsp_s, 32'h2345_6780);
      check("bp_tag", 32'(rsp_tag), 32'd7);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_hs_valid", 32'(rsp_valid), 32'd0);
    check("bp_hs_busy", 32'(busy), 32'd0);
    check("bp_hs_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp2_busy", 32'(busy), 32'd1);
    tick();
    check("bp2_valid", 32'(rsp_valid), 32'd1);
    check("bp2_s", rsp_s, 32'hF800_0000);
    check("bp2_tag", 32'(rsp_tag), 32'd9);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Flush during the second SHIFT cycle of a 5-stage op.
    req_valid = 1'b1;
    req_a = 32'hAAAA_5555; req_shamt = 5'd31; req_fun = 2'b11; req_tag = 5'd12;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("fl_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    do_req("post_fl", 32'h0000_0010, 5'd4, 2'b01, 5'd21, 32'h0000_0001, 2);

    // Flush beats a request offered in the same cycle.
    flush = 1'b1;
    req_valid = 1'b1;
    req_a = 32'h1; req_shamt = 5'd0; req_fun = 2'b00; req_tag = 5'd1;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check("flprio_busy", 32'(busy), 32'd0);
    check("flprio_valid", 32'(rsp_valid), 32'd0);

    // Asynchronous reset while DONE is held.
    req_valid = 1'b1;
    req_a = 32'hCAFE_F00D; req_shamt = 5'd0; req_fun = 2'b00; req_tag = 5'd17;
    tick();
    req_valid = 1'b0;
    check("ar_pre_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(rsp_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_s", rsp_s, 32'h0);
    check("ar_tag", 32'(rsp_tag), 32'd0);
    check("ar_ready", 32'(req_ready), 32'd1);
    tick();
    #3 rst_n = 1'b1;
    tick();
    do_req("post_ar", 32'h8000_0000, 5'd5, 2'b11, 5'd2, 32'hFC00_0000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
